// File: rtl/alu_pkg.sv
// Shared definitions for the sequential handshake ALU: opcodes, FSM states and
// the saturation helper used when ALU_SATURATE_EN is defined.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_ABS = 3'b101;
  localparam logic [2:0] OP_AVG = 3'b110;
  localparam logic [2:0] OP_MAX = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_MUL  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Most positive (neg=0) or most negative (neg=1) w-bit value, in the low w bits.
  function automatic logic [31:0] sat_word(input logic neg, input int unsigned w);
    logic [31:0] max_pos;
    max_pos = (32'd1 << (w - 1)) - 32'd1;
    return neg ? ~max_pos : max_pos;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier core: loads on start, runs WIDTH iterations,
// then pulses done for one cycle; product stays stable until the next start.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_mag,
  input  logic [WIDTH-1:0]     b_mag,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy && (cnt != CNT_LAST)) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end else if (busy) begin
      busy <= 1'b0;
    end
  end

  assign done    = busy && (cnt == CNT_LAST);
  assign product = acc;

endmodule

// File: rtl/alu_seq_hs.sv
// Signed WIDTH-bit ALU with valid/ready on both sides and an iterative multiplier.
// Define ALU_SATURATE_EN to clamp overflowing results instead of wrapping them.
module alu_seq_hs
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_p_i,
  input  logic             reset_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  input  logic [2:0]       inst_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             overflow_o,
  output logic [1:0]       state_dbg_o
);

  // Handshake: a transfer happens on any rising edge where valid && ready.
  // in_ready_o and out_valid_o are functions of state and out_ready_i only.
  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] data_q;
  logic             ovf_q;
  logic             load_res;
  logic             accept, pop, mul_start, mul_done;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_product, prod_s;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] bitw;
  logic [WIDTH:0]   wa, wb, sum;
  logic             alu_ovf, mul_ovf, res_ovf;
  logic [WIDTH-1:0] res_wrap, res_data;

  assign in_ready_o  = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready_i);
  assign out_valid_o = (state == ST_HOLD);
  assign data_o      = data_q;
  assign overflow_o  = ovf_q;
  assign state_dbg_o = state;

  assign accept    = in_valid_i & in_ready_o;
  assign pop       = out_valid_o & out_ready_i;
  assign mul_start = accept & (inst_i == OP_MUL);
  assign a_mag     = data_a_i[WIDTH-1] ? -data_a_i : data_a_i;
  assign b_mag     = data_b_i[WIDTH-1] ? -data_b_i : data_b_i;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk_p_i),
    .rst_n   (reset_n_i),
    .start   (mul_start),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .done    (mul_done),
    .product (mul_product)
  );

  // Non-MUL ops produce a sign-extended WIDTH+1 result; overflow is a top-bit disagreement.
  always_comb begin
    wa   = {a_q[WIDTH-1], a_q};
    wb   = {b_q[WIDTH-1], b_q};
    sum  = wa + wb;
    bitw = '0;
    wide = '0;
    case (op_q)
      OP_ADD: wide = sum;
      OP_SUB: wide = wb - wa;
      OP_AND: begin
        bitw = a_q & b_q;
        wide = {bitw[WIDTH-1], bitw};
      end
      OP_XOR: begin
        bitw = a_q ^ b_q;
        wide = {bitw[WIDTH-1], bitw};
      end
      OP_ABS: wide = a_q[WIDTH-1] ? -wa : wa;
      OP_AVG: wide = {sum[WIDTH], sum[WIDTH:1]};
      OP_MAX: wide = ($signed(a_q) > $signed(b_q)) ? wa : wb;
      default: wide = '0;
    endcase
  end

  assign alu_ovf = wide[WIDTH] ^ wide[WIDTH-1];
  assign prod_s  = neg_q ? -mul_product : mul_product;
  assign mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) | (~|prod_s[2*WIDTH-1:WIDTH-1]));

  assign res_ovf  = (state == ST_MUL) ? mul_ovf : alu_ovf;
  assign res_wrap = (state == ST_MUL) ? prod_s[WIDTH-1:0] : wide[WIDTH-1:0];

`ifdef ALU_SATURATE_EN
  logic res_neg;
  assign res_neg  = (state == ST_MUL) ? prod_s[2*WIDTH-1] : wide[WIDTH];
  assign res_data = res_ovf ? WIDTH'(sat_word(res_neg, int'(WIDTH))) : res_wrap;
`else
  assign res_data = res_wrap;
`endif

  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = (inst_i == OP_MUL) ? ST_MUL : ST_CALC;
      ST_CALC: begin
        state_nxt = ST_HOLD;
        load_res  = 1'b1;
      end
      ST_MUL: if (mul_done) begin
        state_nxt = ST_HOLD;
        load_res  = 1'b1;
      end
      ST_HOLD: begin
        // An accept here implies a pop, since in_ready_o needs out_ready_i in HOLD.
        if (accept)   state_nxt = (inst_i == OP_MUL) ? ST_MUL : ST_CALC;
        else if (pop) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_ADD;
      neg_q  <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q   <= data_a_i;
        b_q   <= data_b_i;
        op_q  <= inst_i;
        neg_q <= data_a_i[WIDTH-1] ^ data_b_i[WIDTH-1];
      end
      if (load_res) begin
        data_q <= res_data;
        ovf_q  <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_hs.sv
// Bench for alu_seq_hs: directed cases with literal results, then random ops
// with random back-pressure, all checked against an integer reference model.
module tb_alu_seq_hs;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = 3'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] data;
  logic         ovf;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int n_pop = 0;
  int n_sent = 0;
  bit rnd_mode = 1'b0;

  logic [W:0] exp_q[$];
  bit         waiting = 1'b0;
  bit         wait_mul = 1'b0;
  int         acc_cyc = 0;

`ifdef ALU_SATURATE_EN
  localparam logic [W-1:0] ADD_OVF_EXP = 8'h7F;
  localparam logic [W-1:0] MUL_OVF_EXP = 8'h7F;
  localparam logic [W-1:0] ABS_OVF_EXP = 8'h7F;
`else
  localparam logic [W-1:0] ADD_OVF_EXP = 8'h96;
  localparam logic [W-1:0] MUL_OVF_EXP = 8'h00;
  localparam logic [W-1:0] ABS_OVF_EXP = 8'h80;
`endif

  alu_seq_hs #(.WIDTH(W)) dut (
    .clk_p_i     (clk),
    .reset_n_i   (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_a_i    (a),
    .data_b_i    (b),
    .inst_i      (op),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (data),
    .overflow_o  (ovf),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic [2:0] mop);
    longint sa, sb, t, hi, lo;
    logic [W-1:0] d;
    logic o;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    case (mop)
      3'd0: t = sa + sb;
      3'd1: t = sb - sa;
      3'd2: t = sa * sb;
      3'd3: t = longint'($signed(ma & mb));
      3'd4: t = longint'($signed(ma ^ mb));
      3'd5: t = (sa < 0) ? -sa : sa;
      3'd6: t = (sa + sb) >>> 1;
      default: t = (sa > sb) ? sa : sb;
    endcase
    o = (t > hi) || (t < lo);
    d = t[W-1:0];
`ifdef ALU_SATURATE_EN
    if (o) d = (t > 0) ? hi[W-1:0] : lo[W-1:0];
`endif
    return {o, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_data", 32'(data), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        exp_q.delete();
        waiting = 1'b0;
      end else begin
        if (out_valid) begin
          if (waiting) begin
            check("latency", 32'(cyc - acc_cyc), wait_mul ? 32'(W + 2) : 32'd2);
            waiting = 1'b0;
          end
          check("queue_depth", 32'(exp_q.size()), 32'd1);
          if (exp_q.size() > 0) begin
            check("result", 32'({ovf, data}), 32'(exp_q[0]));
            check("hold_ready", 32'(in_ready), 32'(out_ready));
            if (out_ready) begin
              void'(exp_q.pop_front());
              n_pop++;
            end
          end
        end else if (waiting) begin
          check("busy_ready", 32'(in_ready), 32'd0);
        end else begin
          check("idle_ready", 32'(in_ready), 32'd1);
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a, b, op));
          waiting  = 1'b1;
          wait_mul = (op == 3'd2);
          acc_cyc  = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic [2:0] sop);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    a = sa;
    b = sb;
    op = sop;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) check("send_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_sent++;
  endtask

  task automatic wait_result(output logic [W-1:0] rd, output logic ro, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 60);
    if (!out_valid) check("result_timeout", 32'(lat), 32'd0);
    rd = data;
    ro = ovf;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] sa, input logic [W-1:0] sb,
                        input logic [2:0] sop, input logic [W-1:0] ed, input logic eo,
                        input int elat);
    logic [W-1:0] rd;
    logic ro;
    int lat;
    send(sa, sb, sop);
    wait_result(rd, ro, lat);
    check({name, "_data"}, 32'(rd), 32'(ed));
    check({name, "_ovf"}, 32'(ro), 32'(eo));
    check({name, "_lat"}, 32'(lat), 32'(elat));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 11))
      0: v = 8'h80;
      1: v = 8'h7F;
      2: v = 8'hFF;
      3: v = 8'h00;
      default: v = W'($urandom_range(0, (1 << W) - 1));
    endcase
    return v;
  endfunction

  // Random back-pressure while the random phase runs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] rd;
    logic ro;
    int lat;
    int guard;

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Model pinned by hand-computed values.
    check("model_add", 32'(model(8'd100, 8'd50, 3'd0)), 32'({1'b1, ADD_OVF_EXP}));
    check("model_mul", 32'(model(8'hF4, 8'd10, 3'd2)), 32'h088);

    run_op("add_ovf", 8'd100, 8'd50, 3'd0, ADD_OVF_EXP, 1'b1, 2);
    run_op("sub", 8'd5, 8'd3, 3'd1, 8'hFE, 1'b0, 2);
    run_op("avg", 8'hFD, 8'd0, 3'd6, 8'hFE, 1'b0, 2);
    run_op("max", 8'hFF, 8'd1, 3'd7, 8'h01, 1'b0, 2);
    run_op("mul", 8'hF4, 8'd10, 3'd2, 8'h88, 1'b0, W + 2);
    run_op("mul_ovf", 8'd16, 8'd16, 3'd2, MUL_OVF_EXP, 1'b1, W + 2);
    run_op("abs_min", 8'h80, 8'd0, 3'd5, ABS_OVF_EXP, 1'b1, 2);
    run_op("abs", 8'hF9, 8'd0, 3'd5, 8'h07, 1'b0, 2);
    run_op("and", 8'hCA, 8'h0F, 3'd3, 8'h0A, 1'b0, 2);

    // Back-pressure: result held, then pop and accept on the same edge.
    out_ready = 1'b0;
    send(8'd1, 8'd2, 3'd0);
    wait_result(rd, ro, lat);
    check("bp_first", 32'(rd), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_data_stable", 32'(data), 32'd3);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_ready_low", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 8'h0F;
    b = 8'hF0;
    op = 3'd4;
    @(negedge clk);
    check("pop_accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_sent++;
    @(negedge clk);
    check("pop_accept_cleared", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("pop_accept_valid", 32'(out_valid), 32'd1);
    check("pop_accept_data", 32'(data), 32'hFF);
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply: discarded, outputs back to reset values.
    send(8'd3, 8'd5, 3'd2);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    check("async_rst_data", 32'(data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("add_after_rst", 8'd1, 8'd1, 3'd0, 8'h02, 1'b0, 2);

    // Random phase: 1000 ops of each opcode, interleaved.
    rnd_mode = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      int gap;
      send(rnd_val(), rnd_val(), 3'(i % 8));
      gap = $urandom_range(0, 1);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_mode = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("no_lost_or_dup", 32'(n_pop), 32'(n_sent - 1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
